// File: rtl/sdram_pll_seq_pkg.sv
// rtl/sdram_pll_seq_pkg.sv - shared state encoding and widths for the SDRAM PLL lock sequencer
package sdram_pll_seq_pkg;

   localparam int STATE_W      = 3;
   localparam int RELOCK_CNT_W = 8;

   // Encoding is visible on state_o, so the values are fixed.
   typedef enum logic [STATE_W-1:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdram_pll_lock_sync.sv
// rtl/sdram_pll_lock_sync.sv - two-flop synchronizer bringing the PLL locked pin into refclk
module sdram_pll_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sdram_pll_lock_sequencer.sv
// rtl/sdram_pll_lock_sequencer.sv - PLL bring-up/relock FSM gating the SDRAM reset tree
// Optional FAULT after repeated lock timeouts: define SDRAM_PLL_RETRY_LIMIT_EN.
module sdram_pll_lock_sequencer
   import sdram_pll_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int LOCK_STABLE    = 1024,
   parameter int MAX_RETRIES    = 8
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic                    pll_locked_i,
   input  logic                    relock_req_i,
   output logic                    pll_rst_o,
   output logic                    sys_rst_o,
   output logic                    ready_o,
   output logic [STATE_W-1:0]      state_o,
   output logic [RELOCK_CNT_W-1:0] relock_count_o,
   output logic                    fault_o
);

   localparam int MAX_P = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT), max2(LOCK_STABLE, MAX_RETRIES));
   localparam int CNT_W = $clog2(MAX_P) + 1;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lock_s;
   logic             relock_evt;

`ifdef SDRAM_PLL_RETRY_LIMIT_EN
   localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);
   logic [RETRY_W-1:0] retry;
`else
   assign fault_o = 1'b0;
`endif

   sdram_pll_lock_sync u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked_i),
      .q   (lock_s)
   );

   // A relock request and a lock loss landing together are one event.
   assign relock_evt = (relock_req_i && (state == S_WAIT_LOCK || state == S_STABLE || state == S_RUN))
                     || (state == S_RUN && !lock_s);

   assign state_o = state;

   always_ff @(posedge refclk) begin
      if (rst) begin
         state          <= S_RESET_PLL;
         cnt            <= '0;
         pll_rst_o      <= 1'b1;
         sys_rst_o      <= 1'b1;
         ready_o        <= 1'b0;
         relock_count_o <= '0;
`ifdef SDRAM_PLL_RETRY_LIMIT_EN
         retry          <= '0;
         fault_o        <= 1'b0;
`endif
      end else if (relock_evt) begin
         state     <= S_RESET_PLL;
         cnt       <= '0;
         pll_rst_o <= 1'b1;
         sys_rst_o <= 1'b1;
         ready_o   <= 1'b0;
         if (relock_count_o != '1)
            relock_count_o <= relock_count_o + 1'b1;
      end else begin
         case (state)
            S_RESET_PLL: begin
               if (cnt == RST_LAST) begin
                  state     <= S_WAIT_LOCK;
                  cnt       <= '0;
                  pll_rst_o <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state <= S_STABLE;
                  cnt   <= '0;
               end else if (cnt == TMO_LAST) begin
                  cnt       <= '0;
                  pll_rst_o <= 1'b1;
`ifdef SDRAM_PLL_RETRY_LIMIT_EN
                  retry <= retry + 1'b1;
                  if (retry == RETRY_LAST) begin
                     state   <= S_FAULT;
                     fault_o <= 1'b1;
                  end else begin
                     state <= S_RESET_PLL;
                  end
`else
                  state <= S_RESET_PLL;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STABLE: begin
               // A dropout here restarts qualification; it is not a timeout.
               if (!lock_s) begin
                  state <= S_WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STB_LAST) begin
                  state     <= S_RUN;
                  cnt       <= '0;
                  sys_rst_o <= 1'b0;
                  ready_o   <= 1'b1;
`ifdef SDRAM_PLL_RETRY_LIMIT_EN
                  retry     <= '0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RUN: begin
               cnt <= '0;
            end
`ifdef SDRAM_PLL_RETRY_LIMIT_EN
            S_FAULT: begin
               if (relock_req_i) begin
                  state   <= S_RESET_PLL;
                  cnt     <= '0;
                  retry   <= '0;
                  fault_o <= 1'b0;
               end
            end
`endif
            default: begin
               state     <= S_RESET_PLL;
               cnt       <= '0;
               pll_rst_o <= 1'b1;
               sys_rst_o <= 1'b1;
               ready_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_pll_lock_sequencer.sv
// tb/tb_sdram_pll_lock_sequencer.sv - directed bench for the SDRAM PLL lock sequencer
module tb_sdram_pll_lock_sequencer;

   logic       refclk = 1'b0;
   logic       rst;
   logic       pll_locked_i;
   logic       relock_req_i;
   logic       pll_rst_o;
   logic       sys_rst_o;
   logic       ready_o;
   logic [2:0] state_o;
   logic [7:0] relock_count_o;
   logic       fault_o;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic track    = 1'b0;
   logic sys_low_seen  = 1'b0;
   logic pll_high_seen = 1'b0;

   always #5 refclk = ~refclk;

   sdram_pll_lock_sequencer #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (100),
      .LOCK_STABLE    (16),
      .MAX_RETRIES    (3)
   ) dut (
      .refclk         (refclk),
      .rst            (rst),
      .pll_locked_i   (pll_locked_i),
      .relock_req_i   (relock_req_i),
      .pll_rst_o      (pll_rst_o),
      .sys_rst_o      (sys_rst_o),
      .ready_o        (ready_o),
      .state_o        (state_o),
      .relock_count_o (relock_count_o),
      .fault_o        (fault_o)
   );

   always @(negedge refclk) begin
      if (track) begin
         if (!sys_rst_o) sys_low_seen = 1'b1;
         if (pll_rst_o)  pll_high_seen = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
      int k = 0;
      while (state_o !== s && k < budget) begin
         tick(1);
         k++;
      end
      expect_eq(tag, 32'(state_o), 32'(s));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      pll_locked_i = 1'b0;
      relock_req_i = 1'b0;
      tick(3);
      expect_eq("rst_state",   32'(state_o), 32'd0);
      expect_eq("rst_pll_rst", 32'(pll_rst_o), 32'd1);
      expect_eq("rst_sys_rst", 32'(sys_rst_o), 32'd1);
      expect_eq("rst_ready",   32'(ready_o), 32'd0);
      expect_eq("rst_relock",  32'(relock_count_o), 32'd0);
      expect_eq("rst_fault",   32'(fault_o), 32'd0);

      // pll_rst_o held for exactly 4 cycles once rst drops
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         expect_eq("pll_rst_hold", 32'(pll_rst_o), 32'd1);
      end
      tick(1);
      expect_eq("pll_rst_release", 32'(pll_rst_o), 32'd0);
      expect_eq("enter_wait", 32'(state_o), 32'd1);

      // clean bring-up: RUN 2 + 16 edges after lock is first sampled
      tick(5);
      pll_locked_i = 1'b1;
      tick(3);
      expect_eq("enter_stable", 32'(state_o), 32'd2);
      tick(15);
      expect_eq("sys_rst_before_run", 32'(sys_rst_o), 32'd1);
      tick(1);
      expect_eq("run_sys_rst", 32'(sys_rst_o), 32'd0);
      expect_eq("run_ready",   32'(ready_o), 32'd1);
      expect_eq("run_state",   32'(state_o), 32'd3);
      expect_eq("run_relock0", 32'(relock_count_o), 32'd0);

      // one-cycle lock loss in RUN
      pll_locked_i = 1'b0;
      tick(1);
      pll_locked_i = 1'b1;
      tick(1);
      expect_eq("loss_sys_rst_l1", 32'(sys_rst_o), 32'd0);
      tick(1);
      expect_eq("loss_sys_rst",  32'(sys_rst_o), 32'd1);
      expect_eq("loss_state",    32'(state_o), 32'd0);
      expect_eq("loss_relock",   32'(relock_count_o), 32'd1);
      expect_eq("loss_pll_rst",  32'(pll_rst_o), 32'd1);
      tick(4);
      expect_eq("rerun_wait",    32'(state_o), 32'd1);
      tick(1);
      expect_eq("rerun_stable",  32'(state_o), 32'd2);
      tick(15);
      expect_eq("rerun_stable_end", 32'(state_o), 32'd2);
      tick(1);
      expect_eq("rerun_run",     32'(state_o), 32'd3);
      expect_eq("rerun_ready",   32'(ready_o), 32'd1);

      // forced relock from RUN, then a glitchy lock
      relock_req_i = 1'b1;
      pll_locked_i = 1'b0;
      tick(1);
      relock_req_i = 1'b0;
      expect_eq("req_state",  32'(state_o), 32'd0);
      expect_eq("req_relock", 32'(relock_count_o), 32'd2);
      tick(4);
      expect_eq("req_wait", 32'(state_o), 32'd1);
      track = 1'b1;
      pll_locked_i = 1'b1;
      tick(10);
      pll_locked_i = 1'b0;
      tick(3);
      expect_eq("glitch_back_to_wait", 32'(state_o), 32'd1);
      pll_locked_i = 1'b1;
      tick(3);
      expect_eq("glitch_restable", 32'(state_o), 32'd2);
      tick(15);
      track = 1'b0;
      expect_eq("glitch_not_yet_run", 32'(state_o), 32'd2);
      tick(1);
      expect_eq("glitch_run",           32'(state_o), 32'd3);
      expect_eq("glitch_sys_rst_held",  32'(sys_low_seen), 32'd0);
      expect_eq("glitch_no_timeout",    32'(pll_high_seen), 32'd0);
      expect_eq("glitch_relock",        32'(relock_count_o), 32'd2);

      // relock request in the same cycle lock_s falls counts once
      pll_locked_i = 1'b0;
      tick(2);
      relock_req_i = 1'b1;
      tick(1);
      relock_req_i = 1'b0;
      expect_eq("req_plus_loss_relock", 32'(relock_count_o), 32'd3);
      expect_eq("req_plus_loss_state",  32'(state_o), 32'd0);
      relock_req_i = 1'b1;
      tick(1);
      relock_req_i = 1'b0;
      expect_eq("req_ignored_in_reset", 32'(relock_count_o), 32'd3);
      expect_eq("req_ignored_state",    32'(state_o), 32'd0);
      tick(3);
      expect_eq("req_ignored_wait",     32'(state_o), 32'd1);

      // saturate the relock counter with requests from WAIT_LOCK
      for (int i = 0; i < 297; i++) begin
         relock_req_i = 1'b1;
         tick(1);
         relock_req_i = 1'b0;
         if (i == 250) expect_eq("relock_at_254", 32'(relock_count_o), 32'd254);
         if (i == 251) expect_eq("relock_at_255", 32'(relock_count_o), 32'd255);
         tick(4);
      end
      expect_eq("relock_saturated", 32'(relock_count_o), 32'd255);
      expect_eq("sat_state_wait",   32'(state_o), 32'd1);

      // lock never arrives: 104-cycle retry period
`ifdef SDRAM_PLL_RETRY_LIMIT_EN
      for (int i = 0; i < 2; i++) begin
         tick(99);
         expect_eq("tmo_wait_pll_low", 32'(pll_rst_o), 32'd0);
         tick(1);
         expect_eq("tmo_pll_rst_rise", 32'(pll_rst_o), 32'd1);
         expect_eq("tmo_state_reset",  32'(state_o), 32'd0);
         tick(3);
         expect_eq("tmo_pll_rst_hold", 32'(pll_rst_o), 32'd1);
         tick(1);
         expect_eq("tmo_pll_rst_fall", 32'(pll_rst_o), 32'd0);
      end
      tick(99);
      expect_eq("tmo3_wait", 32'(state_o), 32'd1);
      tick(1);
      expect_eq("fault_state",   32'(state_o), 32'd4);
      expect_eq("fault_flag",    32'(fault_o), 32'd1);
      expect_eq("fault_pll_rst", 32'(pll_rst_o), 32'd1);
      expect_eq("fault_sys_rst", 32'(sys_rst_o), 32'd1);
      tick(20);
      expect_eq("fault_sticky", 32'(state_o), 32'd4);
      relock_req_i = 1'b1;
      tick(1);
      relock_req_i = 1'b0;
      expect_eq("fault_exit_state", 32'(state_o), 32'd0);
      expect_eq("fault_exit_flag",  32'(fault_o), 32'd0);
`else
      for (int i = 0; i < 10; i++) begin
         tick(99);
         expect_eq("tmo_wait_pll_low", 32'(pll_rst_o), 32'd0);
         tick(1);
         expect_eq("tmo_pll_rst_rise", 32'(pll_rst_o), 32'd1);
         expect_eq("tmo_state_reset",  32'(state_o), 32'd0);
         expect_eq("tmo_no_fault",     32'(fault_o), 32'd0);
         tick(3);
         expect_eq("tmo_pll_rst_hold", 32'(pll_rst_o), 32'd1);
         tick(1);
         expect_eq("tmo_pll_rst_fall", 32'(pll_rst_o), 32'd0);
      end
`endif

      // rst in the middle of STABLE clears everything on the next edge
      pll_locked_i = 1'b1;
      wait_state("reach_stable", 3'd2, 60);
      tick(5);
      expect_eq("mid_stable", 32'(state_o), 32'd2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      expect_eq("mid_rst_state",   32'(state_o), 32'd0);
      expect_eq("mid_rst_pll_rst", 32'(pll_rst_o), 32'd1);
      expect_eq("mid_rst_sys_rst", 32'(sys_rst_o), 32'd1);
      expect_eq("mid_rst_ready",   32'(ready_o), 32'd0);
      expect_eq("mid_rst_relock",  32'(relock_count_o), 32'd0);
      expect_eq("mid_rst_fault",   32'(fault_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
